// File: rtl/hd_result_collector_if.sv
// Result-collector bus: similarity-checker inputs, label strobe, host drain port and status.
// master = upstream/host side, slave = the collector itself.
interface hd_result_collector_if #(
  parameter int IDX_WIDTH   = 16,
  parameter int VAL_WIDTH   = 16,
  parameter int LABEL_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) ();
  logic                   all_done;
  logic [VAL_WIDTH-1:0]   max_val;
  logic [IDX_WIDTH-1:0]   max_index;
  logic                   label_valid;
  logic [LABEL_WIDTH-1:0] label_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [IDX_WIDTH-1:0]   out_index;
  logic [VAL_WIDTH-1:0]   out_val;
  logic                   out_correct;
  logic                   out_labeled;
  logic [CNT_WIDTH-1:0]   sample_count;
  logic [CNT_WIDTH-1:0]   correct_count;
  logic                   overflow;

  modport master (
    output all_done, max_val, max_index, label_valid, label_in, out_ready,
    input  out_valid, out_index, out_val, out_correct, out_labeled,
           sample_count, correct_count, overflow
  );

  modport slave (
    input  all_done, max_val, max_index, label_valid, label_in, out_ready,
    output out_valid, out_index, out_val, out_correct, out_labeled,
           sample_count, correct_count, overflow
  );
endinterface

// File: rtl/hd_result_collector.sv
// Captures one classification result per all_done pulse into a small FIFO drained by the host.
// Define HD_RESULT_ACCURACY_EN to compile in label compare and correct-prediction counting.
module hd_result_collector #(
  parameter int FIFO_DEPTH  = 8,
  parameter int IDX_WIDTH   = 16,
  parameter int VAL_WIDTH   = 16,
  parameter int LABEL_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  hd_result_collector_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [IDX_WIDTH-1:0] idx;
    logic [VAL_WIDTH-1:0] val;
    logic                 correct;
    logic                 labeled;
  } entry_t;

  entry_t               mem_q [FIFO_DEPTH];
  entry_t               new_entry;
  entry_t               head;
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic                 empty, full, capture, pop, push, drop;
  logic                 entry_correct, entry_labeled;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign capture = bus.all_done & ~done_q;
  assign pop     = ~empty & bus.out_ready;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

`ifdef HD_RESULT_ACCURACY_EN
  logic [LABEL_WIDTH-1:0] label_reg_q, label_reg_d;
  logic                   label_armed_q, label_armed_d;
  logic [CNT_WIDTH-1:0]   correct_cnt_q, correct_cnt_d;

  // Zero-extending the label also rejects indices with nonzero upper bits.
  assign entry_labeled = label_armed_q;
  assign entry_correct = label_armed_q & (bus.max_index == IDX_WIDTH'(label_reg_q));

  always_comb begin
    label_reg_d   = label_reg_q;
    label_armed_d = label_armed_q;
    correct_cnt_d = correct_cnt_q;
    if (clear) begin
      label_reg_d   = '0;
      label_armed_d = 1'b0;
      correct_cnt_d = '0;
    end else begin
      if (bus.label_valid) begin
        label_reg_d   = bus.label_in;
        label_armed_d = 1'b1;
      end else if (capture) begin
        label_armed_d = 1'b0;
      end
      if (capture && entry_correct && !(&correct_cnt_q))
        correct_cnt_d = correct_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      label_reg_q   <= '0;
      label_armed_q <= 1'b0;
      correct_cnt_q <= '0;
    end else begin
      label_reg_q   <= label_reg_d;
      label_armed_q <= label_armed_d;
      correct_cnt_q <= correct_cnt_d;
    end
  end

  assign bus.correct_count = correct_cnt_q;
`else
  logic unused_label;
  assign unused_label      = ^{bus.label_valid, bus.label_in};
  assign entry_labeled     = 1'b0;
  assign entry_correct     = 1'b0;
  assign bus.correct_count = '0;
`endif

  always_comb begin
    new_entry.idx     = bus.max_index;
    new_entry.val     = bus.max_val;
    new_entry.correct = entry_correct;
    new_entry.labeled = entry_labeled;
  end

  // done_q tracks all_done in every cycle, including clear, so a level that is
  // already high when clear is released does not produce a capture.
  always_comb begin
    done_d       = bus.all_done;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    sample_cnt_d = sample_cnt_q;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      overflow_d   = 1'b0;
      sample_cnt_d = '0;
    end else begin
      wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
      overflow_d = overflow_q | drop;
      if (capture && !(&sample_cnt_q))
        sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else if (push && !clear) begin
      mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
    end
  end

  assign head             = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.out_valid    = ~empty;
  assign bus.out_index    = head.idx;
  assign bus.out_val      = head.val;
  assign bus.out_correct  = head.correct;
  assign bus.out_labeled  = head.labeled;
  assign bus.sample_count = sample_cnt_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_hd_result_collector.sv
// Directed bench for hd_result_collector: cycle table for capture/label behaviour,
// hand-written sequences for overflow, full push/pop, clear priority and reset release.
module tb_hd_result_collector;
`ifdef HD_RESULT_ACCURACY_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hd_result_collector_if #(.IDX_WIDTH(16), .VAL_WIDTH(16), .LABEL_WIDTH(8), .CNT_WIDTH(16)) bus ();

  hd_result_collector #(
    .FIFO_DEPTH(8), .IDX_WIDTH(16), .VAL_WIDTH(16), .LABEL_WIDTH(8), .CNT_WIDTH(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          clr;
    bit          done;
    logic [15:0] idx;
    logic [15:0] val;
    bit          lv;
    logic [7:0]  lab;
    bit          rdy;
    int          reps;
    bit          e_v;
    logic [15:0] e_idx;
    logic [15:0] e_val;
    bit          e_c;
    bit          e_l;
    int          e_s;
    int          e_cc;
    bit          e_ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit clr, bit done, logic [15:0] idx, logic [15:0] val, bit lv,
                              logic [7:0] lab, bit rdy, int reps, bit e_v, logic [15:0] e_idx,
                              logic [15:0] e_val, bit e_c, bit e_l, int e_s, int e_cc, bit e_ov);
    vec_t v;
    v.clr = clr; v.done = done; v.idx = idx; v.val = val; v.lv = lv; v.lab = lab;
    v.rdy = rdy; v.reps = reps; v.e_v = e_v; v.e_idx = e_idx; v.e_val = e_val;
    v.e_c = e_c; v.e_l = e_l; v.e_s = e_s; v.e_cc = e_cc; v.e_ov = e_ov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then let the rising edge act and settle.
  task automatic cyc(input bit clr, input bit done, input logic [15:0] idx, input logic [15:0] val,
                     input bit lv, input logic [7:0] lab, input bit rdy);
    @(negedge clk);
    clear           = clr;
    bus.all_done    = done;
    bus.max_index   = idx;
    bus.max_val     = val;
    bus.label_valid = lv;
    bus.label_in    = lab;
    bus.out_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] idx, input logic [15:0] val);
    cyc(0, 1, idx, val, 0, 0, 0);
    cyc(0, 0, idx, val, 0, 0, 0);
  endtask

  initial begin
    int n;
    logic [15:0] exp_idx [8];

    bus.all_done = 0; bus.max_index = 0; bus.max_val = 0;
    bus.label_valid = 0; bus.label_in = 0; bus.out_ready = 0;

    // Columns: clr done idx val lv lab rdy reps | v idx val c l samples correct ovf
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,8'd0,0,1, 0,16'h0000,16'h0000,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1,8'd5,0,1, 0,16'h0000,16'h0000,0,0,0,0,0));
    vecs.push_back(mk(0,1,16'h0005,16'h0123,0,8'd0,0,1, 1,16'h0005,16'h0123,1,1,1,1,0));
    vecs.push_back(mk(0,1,16'h0005,16'h0123,0,8'd0,0,9, 1,16'h0005,16'h0123,1,1,1,1,0));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0,8'd0,1,1, 0,16'h0000,16'h0000,0,0,1,1,0));
    vecs.push_back(mk(1,0,16'h0000,16'h0000,0,8'd0,0,1, 0,16'h0000,16'h0000,0,0,0,0,0));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1,8'd3,0,1, 0,16'h0000,16'h0000,0,0,0,0,0));
    vecs.push_back(mk(0,1,16'h0004,16'h0AAA,0,8'd0,0,1, 1,16'h0004,16'h0AAA,0,1,1,0,0));
    vecs.push_back(mk(0,0,16'h0004,16'h0AAA,0,8'd0,0,1, 1,16'h0004,16'h0AAA,0,1,1,0,0));
    vecs.push_back(mk(0,1,16'h0007,16'h0BBB,0,8'd0,0,1, 1,16'h0004,16'h0AAA,0,1,2,0,0));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0,8'd0,1,1, 1,16'h0007,16'h0BBB,0,0,2,0,0));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0,8'd0,1,1, 0,16'h0000,16'h0000,0,0,2,0,0));
    // Label strobe coinciding with a capture arms the next result, not this one.
    vecs.push_back(mk(0,1,16'h0009,16'h0009,1,8'd9,0,1, 1,16'h0009,16'h0009,0,0,3,0,0));
    vecs.push_back(mk(0,0,16'h0009,16'h0009,0,8'd0,0,1, 1,16'h0009,16'h0009,0,0,3,0,0));
    vecs.push_back(mk(0,1,16'h0009,16'h0019,0,8'd0,0,1, 1,16'h0009,16'h0009,0,0,4,1,0));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0,8'd0,1,1, 1,16'h0009,16'h0019,1,1,4,1,0));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,1,8'd2,1,1, 0,16'h0000,16'h0000,0,0,4,1,0));
    // Low byte matches the label but the upper index bits do not.
    vecs.push_back(mk(0,1,16'h0102,16'h0055,0,8'd0,0,1, 1,16'h0102,16'h0055,0,1,5,1,0));
    vecs.push_back(mk(0,0,16'h0000,16'h0000,0,8'd0,1,1, 0,16'h0000,16'h0000,0,0,5,1,0));

    // Reset state
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_index", bus.out_index, 0);
    chk("rst_val", bus.out_val, 0);
    chk("rst_correct", bus.out_correct, 0);
    chk("rst_labeled", bus.out_labeled, 0);
    chk("rst_samples", bus.sample_count, 0);
    chk("rst_correct_cnt", bus.correct_count, 0);
    chk("rst_overflow", bus.overflow, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[r]) begin
      for (int k = 0; k < vecs[r].reps; k++) begin
        cyc(vecs[r].clr, vecs[r].done, vecs[r].idx, vecs[r].val, vecs[r].lv, vecs[r].lab, vecs[r].rdy);
        chk($sformatf("row%0d_valid", r), bus.out_valid, vecs[r].e_v);
        if (vecs[r].e_v) begin
          chk($sformatf("row%0d_index", r), bus.out_index, vecs[r].e_idx);
          chk($sformatf("row%0d_val", r), bus.out_val, vecs[r].e_val);
          chk($sformatf("row%0d_correct", r), bus.out_correct, vecs[r].e_c & ACC);
          chk($sformatf("row%0d_labeled", r), bus.out_labeled, vecs[r].e_l & ACC);
        end
        chk($sformatf("row%0d_samples", r), bus.sample_count, vecs[r].e_s);
        chk($sformatf("row%0d_correct_cnt", r), bus.correct_count, ACC ? vecs[r].e_cc : 0);
        chk($sformatf("row%0d_overflow", r), bus.overflow, vecs[r].e_ov);
      end
    end

    // Overflow: ten pulses into an undrained depth-8 FIFO
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) pulse(16'(i + 1), 16'(i * 3));
    chk("ovf_samples", bus.sample_count, 10);
    chk("ovf_flag", bus.overflow, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_pop%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("ovf_pop%0d_index", i), bus.out_index, 16'(i + 1));
      chk($sformatf("ovf_pop%0d_val", i), bus.out_val, 16'(i * 3));
      cyc(0, 0, 0, 0, 0, 0, 1);
    end
    chk("ovf_drained", bus.out_valid, 0);
    chk("ovf_flag_sticky", bus.overflow, 1);

    // Full FIFO with a capture and a pop in the same cycle
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) pulse(16'(i + 1), 16'h0);
    chk("full_no_ovf_before", bus.overflow, 0);
    cyc(0, 1, 16'd100, 16'h0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("full_pp_overflow", bus.overflow, 0);
    chk("full_pp_samples", bus.sample_count, 9);
    for (int i = 0; i < 7; i++) exp_idx[i] = 16'(i + 2);
    exp_idx[7] = 16'd100;
    n = 0;
    while (bus.out_valid && n < 20) begin
      if (n < 8) chk($sformatf("full_pp_pop%0d_index", n), bus.out_index, exp_idx[n]);
      n++;
      cyc(0, 0, 0, 0, 0, 0, 1);
    end
    chk("full_pp_occupancy", n, 8);

    // Clear wins over a rising all_done and a pop in the same cycle
    cyc(1, 0, 0, 0, 0, 0, 0);
    pulse(16'd40, 16'h1);
    pulse(16'd41, 16'h2);
    chk("clr_pre_samples", bus.sample_count, 2);
    cyc(1, 1, 16'd50, 16'h3, 0, 0, 1);
    chk("clr_valid", bus.out_valid, 0);
    chk("clr_samples", bus.sample_count, 0);
    chk("clr_overflow", bus.overflow, 0);
    cyc(0, 1, 16'd50, 16'h3, 0, 0, 0);
    chk("clr_no_capture_valid", bus.out_valid, 0);
    chk("clr_no_capture_samples", bus.sample_count, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 16'd51, 16'h4, 0, 0, 0);
    chk("clr_after_valid", bus.out_valid, 1);
    chk("clr_after_index", bus.out_index, 51);
    chk("clr_after_samples", bus.sample_count, 1);

    // Reset released while all_done is already high captures on the first edge
    @(negedge clk);
    bus.all_done  = 1;
    bus.max_index = 16'd77;
    bus.max_val   = 16'h0777;
    bus.out_ready = 0;
    reset = 1'b0;
    #2;
    chk("rst2_valid", bus.out_valid, 0);
    chk("rst2_samples", bus.sample_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_capture_valid", bus.out_valid, 1);
    chk("rst2_capture_index", bus.out_index, 77);
    chk("rst2_capture_samples", bus.sample_count, 1);
    cyc(0, 1, 16'd77, 16'h0777, 0, 0, 0);
    chk("rst2_single_capture", bus.sample_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hd_result_collector.md
# hd_result_collector

Downstream stage of the HD accelerator top level. It watches the similarity checker's `all_done`, `max_val` and `max_index` outputs and captures one classification result per inference. Each result is stored in a small FIFO that the host drains over a valid/ready port. Optionally, each result is compared against a host-supplied ground-truth label and running sample and correct-prediction counters are maintained.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: result entries buffered; must be a power of two, ≥ 2.
- `IDX_WIDTH`, 16: width of `max_index`.
- `VAL_WIDTH`, 16: width of `max_val`.
- `LABEL_WIDTH`, 8: ground-truth label width; compared against `max_index[LABEL_WIDTH-1:0]`.
- `CNT_WIDTH`, 16: width of the sample and correct counters.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of FIFO, counters, label register and sticky flags.
- `all_done`  in  1  done level from the similarity checker; may stay high for many cycles.
- `max_val`  in  VAL_WIDTH  winning similarity score; valid while `all_done` is high.
- `max_index`  in  IDX_WIDTH  winning class index; valid while `all_done` is high.
- `label_valid`  in  1  strobe that loads `label_in`.
- `label_in`  in  LABEL_WIDTH  ground-truth class for the next result.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  host accepts the head entry.
- `out_index`  out  IDX_WIDTH  head entry's index.
- `out_val`  out  VAL_WIDTH  head entry's score.
- `out_correct`  out  1  head entry matched its label.
- `out_labeled`  out  1  a label was armed when the head entry was captured.
- `sample_count`  out  CNT_WIDTH  results captured since reset or clear.
- `correct_count`  out  CNT_WIDTH  labeled results that matched.
- `overflow`  out  1  sticky; at least one result was dropped because the FIFO was full.

## Operation
**Capture**
- `all_done` is registered into `done_q`.
- A capture event is `all_done & ~done_q`, i.e. a rising edge. Exactly one capture occurs per high pulse, regardless of its length.
- On a capture event, `{max_index, max_val, correct, labeled}` is pushed into the FIFO.
  - `labeled` = `label_armed`.
  - `correct` = `label_armed & (max_index[LABEL_WIDTH-1:0] == label_reg) & (max_index[IDX_WIDTH-1:LABEL_WIDTH] == 0)`.
- Capture consumes the label: `label_armed` clears.
- If `label_valid` is high in the same cycle as a capture, the label register is loaded with the new value and remains armed for the next result. The current capture uses the previous label state.

**FIFO**
- Circular buffer with read/write pointers one bit wider than the address (log2(FIFO_DEPTH)+1 bits).
- Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal.
- A pop occurs when `out_valid & out_ready`.
- Push while full with a simultaneous pop: both operations proceed and the entry is accepted.
- Push while full without a pop: the entry is dropped and `overflow` is set. `sample_count` still increments.
- Pop while empty: ignored.

**Counters**
- `sample_count` increments on every capture event.
- `correct_count` increments on every capture with `correct=1`.
- Both counters saturate at all ones and never wrap.

**Clear and reset**
- `clear` has priority over capture, label load and pop in the same cycle.
- `clear` empties the FIFO, zeros both counters, `overflow`, `label_armed` and `label_reg`, and sets `done_q` = `all_done`. This prevents a spurious capture if `all_done` is already high.

## Timing
- Reset values: `out_valid`=0, `out_index`=0, `out_val`=0, `out_correct`=0, `out_labeled`=0, `sample_count`=0, `correct_count`=0, `overflow`=0. Internally, `done_q`=0 and pointers=0.
- Capture latency: `all_done` rising at edge t results in `out_valid`=1 after edge t+1, with the counters updated at that same edge.
- `out_*` data fields come directly from the FIFO head and are stable while `out_valid & ~out_ready`.
- Throughput: one push and one pop per cycle.
- Deassertion of `reset` while `all_done` is high causes a capture on the first active edge.

## Configuration
- `HD_RESULT_ACCURACY_EN` defined: label register, compare logic and `correct_count` are compiled in, as described above.
- Not defined: these are compiled out. `out_correct`, `out_labeled` and `correct_count` are tied to 0, and `label_valid`/`label_in` are ignored. `sample_count`, the FIFO and `overflow` are unchanged.

## Test plan
- **Single result:** reset, load label 5, then `all_done` high for 10 cycles with `max_index`=5 and `max_val`=0x0123. Expect exactly one entry `{5, 0x0123, correct=1, labeled=1}`, `out_valid` one cycle after the rise, `sample_count`=1, `correct_count`=1.
- **Mismatch and unlabeled:** label 3 with `max_index`=4, then a second pulse with no new label. Expect entries with correct=0/labeled=1, then correct=0/labeled=0. Expect `correct_count`=0 and `sample_count`=2.
- **Overflow:** hold `out_ready`=0 and send 10 pulses with `FIFO_DEPTH`=8. Expect 8 entries holding the first 8 indices in order, `overflow`=1 and `sample_count`=10. Draining yields exactly 8 pops.
- **Full with simultaneous push/pop:** fill to 8, then pulse `all_done` while `out_ready`=1. Expect no overflow, an occupancy of 8, and the new entry last.
- **Clear priority:** `clear` asserted while `all_done` rises and `out_ready`=1. Expect the FIFO empty, counters at 0, and no capture on the following cycle even though `all_done` is still high.
- **Macro off:** with `HD_RESULT_ACCURACY_EN` undefined, repeat the first scenario. Expect `out_correct`=0, `out_labeled`=0, `correct_count`=0 and `sample_count`=1.
